slave_arbiter: RTL and testbench
================================

# slave_arbiter

Per-slave round-robin arbiter for the multilayer AHB interconnect. One instance sits in front of each slave port and produces the one-hot `bus_grant` vector that drives that slave's input multiplexer. It also produces a registered data-phase owner vector for write-data and response routing, plus per-master wait indications. Arbitration advances only on cycles where the slave signals ready, and a bounded hold count prevents starvation.

## Interface
- `NUM_MASTERS`, default 2: number of requesting masters, ≥2.
- `MAX_HOLD`, default 4: maximum consecutive address phases one master keeps the grant while others request, ≥1.
- `i_hclk`  in  1: clock; all state changes on the rising edge.
- `i_hresetn`  in  1: asynchronous, active-low reset.
- `i_req`  in  NUM_MASTERS: master i has a transfer (htrans NONSEQ) decoded to this slave.
- `i_hready`  in  1: slave ready; a high value completes the current data phase and accepts the current address phase.
- `o_bus_grant`  out  NUM_MASTERS: one-hot or zero, registered; address-phase owner; feeds the slave mux select.
- `o_data_grant`  out  NUM_MASTERS: one-hot or zero, registered; data-phase owner.
- `o_wait`  out  NUM_MASTERS: combinational, `i_req & ~o_bus_grant`; the master must stall (its hready is forced low).

## Operation
- State machine with two states:
  - **IDLE**: `o_bus_grant` is 0.
  - **GRANTED**: `o_bus_grant` is one-hot, with owner index `g`.
- An update happens only on edges where `i_hready`=1. When `i_hready`=0, every register holds: state, grant, data grant, pointer and counter.
- **IDLE**, on ready:
  - If any `i_req` is set, grant the first requester at or after `ptr` (wrapping modulo NUM_MASTERS). Go to GRANTED, set `hold_cnt`=0, and set `ptr`=winner+1 mod N.
  - Otherwise stay in IDLE.
- **GRANTED**, on ready, evaluated in this priority order:
  - If no `i_req` is set: go to IDLE, with grant 0.
  - Else, if `i_req[g]`=1 and (`hold_cnt` < MAX_HOLD−1, or no other request is present): keep `g`. Set `hold_cnt` to `hold_cnt`+1, saturating at MAX_HOLD−1.
  - Else: re-arbitrate from `ptr`, which already points past `g`. The winner gets `hold_cnt`=0 and `ptr`=winner+1.
- Data owner: on every ready edge, `o_data_grant` takes the pre-update `o_bus_grant`. A transfer accepted in the address phase therefore owns the data phase in the next ready cycle.
- Widths and arithmetic:
  - `ptr` is $clog2(NUM_MASTERS) bits, and wraps explicitly at NUM_MASTERS−1 (not at a power of two).
  - `hold_cnt` is $clog2(MAX_HOLD)+1 bits.
- Boundary conditions:
  - A single requester is re-granted indefinitely; the hold limit applies only when another master is requesting.
  - Simultaneous requests from all masters are served in strict rotation, each for up to MAX_HOLD beats.
  - If the owner drops its request while the slave is stalled, the grant is still held until `i_hready`=1.
  - An asynchronous reset mid-transfer clears everything immediately, with no completion of the pending data phase.

## Timing
- Reset values:
  - `o_bus_grant`=0 and `o_data_grant`=0.
  - State IDLE, `ptr`=0, `hold_cnt`=0.
  - `o_wait` equals `i_req`.
- Request-to-grant latency is 1 cycle from the first ready edge that sees the request.
- `o_data_grant` lags `o_bus_grant` by exactly one ready edge.
- `o_wait` has no register stage. Its path is `i_req` → `o_wait` only, with no loop through `i_hready`.

## Structure
- Shared package `interconnect_pkg`:
  - the state enum (`ARB_IDLE`, `ARB_GRANTED`);
  - a `clog2`-based index width helper, reused by `slave_mux` and the decoders.
- Sub-module `rr_picker`: combinational find-first-set starting at `ptr` with wrap. Inputs are the request vector and `ptr`; outputs are the one-hot winner and its index.
- The top level holds the FSM, counter, pointer and data-grant register.

## Test plan
All scenarios use N=2 and MAX_HOLD=4.
- **Reset**: assert `i_hresetn`=0 while `i_req`=2'b11. Require both grants = 0 and `o_wait`=2'b11. Release reset; after the first ready edge, require `o_bus_grant`=2'b01.
- **Contention rotation**: hold `i_req`=2'b11 and `i_hready`=1 for 12 cycles. Require the grant sequence 01×4, 10×4, 01×4.
- **Single requester**: hold `i_req`=2'b10 for 10 cycles. Require `o_bus_grant`=2'b10 throughout, with no gaps.
- **Stall hold**: owner is master 0. Drive `i_hready`=0 for 3 cycles while `i_req` goes 2'b10. Require the grant to stay at 2'b01 and `o_data_grant` to stay unchanged. On the first `i_hready`=1 edge, require the grant to become 2'b10.
- **Data lag**: grant 2'b01 → 2'b10 on ready edge k. Require `o_data_grant`=2'b01 after edge k and 2'b10 after edge k+1.
- **Idle return**: `i_req` goes 2'b01 → 2'b00. Require grant 0 on the next ready edge, then `o_data_grant`=0 one ready edge later.

Source files
------------

// File: rtl/interconnect_pkg.sv
// Shared definitions for the multilayer AHB interconnect: arbiter state
// encoding and the index-width helper used by arbiters, muxes and decoders.
package interconnect_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // Bits needed to index n items; never less than one so a port always exists.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first-set: returns the first set request at
// or after i_ptr, wrapping at NUM_MASTERS-1. Zero grant when nothing requests.
module rr_picker
  import interconnect_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IW-1:0]          i_ptr,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [IW-1:0]          o_idx
);

  int   w_pos;
  logic w_found;

  // Scan NUM_MASTERS slots starting at the pointer; first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_MASTERS;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/slave_arbiter.sv
// Per-slave round-robin arbiter. Produces the registered address-phase owner
// (slave mux select), the registered data-phase owner, and combinational
// per-master wait. All state advances only on edges where the slave is ready.
// Handshake: a master's transfer is accepted on a rising edge where i_req is
// set, the master holds the pre-edge o_bus_grant bit and i_hready=1; o_wait
// tells every other requesting master to stall.
module slave_arbiter
  import interconnect_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 4
) (
  input  logic                   i_hclk,
  input  logic                   i_hresetn,
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_hready,
  output logic [NUM_MASTERS-1:0] o_bus_grant,
  output logic [NUM_MASTERS-1:0] o_data_grant,
  output logic [NUM_MASTERS-1:0] o_wait,
  output logic                   o_dbg_state
);

  localparam int IW = idx_width(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD) + 1;

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [NUM_MASTERS-1:0] r_data_grant, w_data_nxt;
  logic [IW-1:0]          r_ptr, w_ptr_nxt;
  logic [HW-1:0]          r_hold, w_hold_nxt;

  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [IW-1:0]          w_pick_idx;
  logic [IW-1:0]          w_ptr_after;
  logic                   w_any_req;
  logic                   w_own_req;
  logic                   w_others;
  logic                   w_hold_below;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_picker (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  // Request qualifiers and the post-win pointer (explicit wrap, not power of 2).
  always_comb begin
    w_any_req    = |i_req;
    w_own_req    = |(i_req & r_grant);
    w_others     = |(i_req & ~r_grant);
    w_hold_below = (r_hold < HW'(MAX_HOLD - 1));
    w_ptr_after  = (w_pick_idx == IW'(NUM_MASTERS - 1)) ? '0 : w_pick_idx + IW'(1);
  end

  // Next-state logic: everything holds unless the slave is ready.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_data_nxt  = r_data_grant;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    if (i_hready) begin
      w_data_nxt = r_grant;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            w_state_nxt = ARB_GRANTED;
            w_grant_nxt = w_pick_grant;
            w_ptr_nxt   = w_ptr_after;
            w_hold_nxt  = '0;
          end
        end
        ARB_GRANTED: begin
          if (!w_any_req) begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
          end else if (w_own_req && (w_hold_below || !w_others)) begin
            // Owner keeps the bus; counter saturates so a lone owner never expires.
            w_hold_nxt = w_hold_below ? r_hold + HW'(1) : r_hold;
          end else begin
            // Pointer already sits past the owner, so the owner goes last.
            w_grant_nxt = w_pick_grant;
            w_ptr_nxt   = w_ptr_after;
            w_hold_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
        end
      endcase
    end
  end

  // State registers; async reset drops any pending data phase immediately.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_data_grant <= '0;
      r_ptr        <= '0;
      r_hold       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_data_grant <= w_data_nxt;
      r_ptr        <= w_ptr_nxt;
      r_hold       <= w_hold_nxt;
    end
  end

  assign o_bus_grant  = r_grant;
  assign o_data_grant = r_data_grant;
  assign o_wait       = i_req & ~r_grant;
  assign o_dbg_state  = (r_state == ARB_GRANTED);

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed bench for slave_arbiter (N=2, MAX_HOLD=4). The driver pushes the
// hand-computed post-edge {bus_grant, data_grant, wait} into exp_q; a monitor
// pops and compares after every rising edge.
module tb_slave_arbiter;

  localparam int N = 2;
  localparam int W = 3 * N;

  logic         i_hclk;
  logic         i_hresetn;
  logic [N-1:0] i_req;
  logic         i_hready;
  logic [N-1:0] o_bus_grant;
  logic [N-1:0] o_data_grant;
  logic [N-1:0] o_wait;
  logic         o_dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_total;
  int           n_pass;

  slave_arbiter #(
    .NUM_MASTERS (N),
    .MAX_HOLD    (4)
  ) dut (
    .i_hclk       (i_hclk),
    .i_hresetn    (i_hresetn),
    .i_req        (i_req),
    .i_hready     (i_hready),
    .o_bus_grant  (o_bus_grant),
    .o_data_grant (o_data_grant),
    .o_wait       (o_wait),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock / reset
  initial begin
    i_hclk = 1'b0;
    forever #5 i_hclk = ~i_hclk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Driver: apply inputs for one edge and queue the expected post-edge outputs.
  task automatic drive(input string name, input logic [N-1:0] req, input logic rdy,
                       input logic [N-1:0] ebus, input logic [N-1:0] edata);
    i_req    = req;
    i_hready = rdy;
    exp_q.push_back({ebus, edata, req & ~ebus});
    name_q.push_back(name);
    @(posedge i_hclk);
    #3;
  endtask

  // Monitor / scoreboard
  always @(posedge i_hclk) begin
    logic [W-1:0] e;
    string        nm;
    #2;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, ".bus"},  8'(o_bus_grant),  8'(e[3*N-1:2*N]));
      check({nm, ".data"}, 8'(o_data_grant), 8'(e[2*N-1:N]));
      check({nm, ".wait"}, 8'(o_wait),       8'(e[N-1:0]));
    end
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    i_hresetn = 1'b0;
    i_req     = 2'b11;
    i_hready  = 1'b1;
    repeat (3) @(posedge i_hclk);
    #3;
    check("reset.bus",   8'(o_bus_grant),  8'h0);
    check("reset.data",  8'(o_data_grant), 8'h0);
    check("reset.wait",  8'(o_wait),       8'h3);
    check("reset.state", 8'(o_dbg_state),  8'h0);
    i_hresetn = 1'b1;

    // Contention rotation: 01 x4, 10 x4, 01 x4 (first edge also is reset release)
    drive("rot1",  2'b11, 1'b1, 2'b01, 2'b00);
    drive("rot2",  2'b11, 1'b1, 2'b01, 2'b01);
    drive("rot3",  2'b11, 1'b1, 2'b01, 2'b01);
    drive("rot4",  2'b11, 1'b1, 2'b01, 2'b01);
    drive("rot5",  2'b11, 1'b1, 2'b10, 2'b01);
    drive("rot6",  2'b11, 1'b1, 2'b10, 2'b10);
    drive("rot7",  2'b11, 1'b1, 2'b10, 2'b10);
    drive("rot8",  2'b11, 1'b1, 2'b10, 2'b10);
    drive("rot9",  2'b11, 1'b1, 2'b01, 2'b10);
    drive("rot10", 2'b11, 1'b1, 2'b01, 2'b01);
    drive("rot11", 2'b11, 1'b1, 2'b01, 2'b01);
    drive("rot12", 2'b11, 1'b1, 2'b01, 2'b01);

    // Single requester: master 1 keeps the bus with no gaps
    drive("single1", 2'b10, 1'b1, 2'b10, 2'b01);
    for (int i = 2; i <= 10; i++) drive($sformatf("single%0d", i), 2'b10, 1'b1, 2'b10, 2'b10);

    // Move ownership to master 0, then stall while request switches
    drive("own0a",  2'b01, 1'b1, 2'b01, 2'b10);
    drive("own0b",  2'b01, 1'b1, 2'b01, 2'b01);
    drive("stall1", 2'b10, 1'b0, 2'b01, 2'b01);
    drive("stall2", 2'b10, 1'b0, 2'b01, 2'b01);
    drive("stall3", 2'b10, 1'b0, 2'b01, 2'b01);
    // Data lag: edge k flips bus grant, data follows on k+1
    drive("lag_k",  2'b10, 1'b1, 2'b10, 2'b01);
    drive("lag_k1", 2'b10, 1'b1, 2'b10, 2'b10);

    // Idle return
    drive("idle_a", 2'b01, 1'b1, 2'b01, 2'b10);
    drive("idle_b", 2'b00, 1'b1, 2'b00, 2'b01);
    drive("idle_c", 2'b00, 1'b1, 2'b00, 2'b00);
    drive("idle_stall", 2'b01, 1'b0, 2'b00, 2'b00);
    // Pointer sits at 1 after master 0 last won; wrap finds master 0
    drive("idle_wrap", 2'b01, 1'b1, 2'b01, 2'b00);
    drive("mid_a", 2'b11, 1'b1, 2'b01, 2'b01);

    // Asynchronous reset mid-cycle while master 0 owns both phases
    #2;
    i_hresetn = 1'b0;
    #1;
    check("areset.bus",  8'(o_bus_grant),  8'h0);
    check("areset.data", 8'(o_data_grant), 8'h0);
    check("areset.wait", 8'(o_wait),       8'h3);
    @(posedge i_hclk);
    #3;
    i_hresetn = 1'b1;
    // Pointer back at 0: master 1 is the only requester and wins
    drive("post_rst1", 2'b10, 1'b1, 2'b10, 2'b00);
    drive("post_rst2", 2'b10, 1'b1, 2'b10, 2'b10);

    repeat (3) @(posedge i_hclk);
    #3;
    check("drain", 8'(exp_q.size()), 8'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
